// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline types and constants
// Purpose: XLEN default, canonical NOP encoding and the IF/ID pipeline entry.
// Ports: none (package).
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// rtl/if_prefetch_stage_if.sv - fetch-stage instruction memory and decode-side bus
// Purpose: bundles the imem request/response channel and the IF/ID output handshake.
// Ports (master = fetch stage):
//   imem_req_valid/imem_req_ready/imem_req_addr - request channel
//   imem_rsp_valid/imem_rsp_data                - in-order response channel
//   out_valid/out_ready/out                     - queue head towards decode
interface if_prefetch_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [XLEN-1:0]     imem_req_addr;
  logic                imem_rsp_valid;
  logic [XLEN-1:0]     imem_rsp_data;
  logic                out_valid;
  logic                out_ready;
  riscv_pkg::if_id_t   out;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output out_valid, out,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  out_valid, out,
    output out_ready
  );

endinterface

// File: rtl/if_prefetch_fifo.sv
// rtl/if_prefetch_fifo.sv - synchronous FIFO with flush, push/pop in one cycle and count
// Purpose: storage for the prefetch queue and the in-order PC tag queue.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   flush_i             - empties the FIFO; overrides push and pop
//   push_i/push_data_i  - write (accepted when not full, or full with a pop)
//   pop_i               - remove head (ignored when empty)
//   head_o, count_o     - current head entry and occupancy
module if_prefetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap so DEPTH need not be a power of two (tag queue).
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - instruction fetch stage with decoupled prefetch queue
// Purpose: issues in-order imem requests (up to MAX_OUTSTANDING in flight), queues
//   {pc, pc_plus4, instr} for decode, and flushes/drops stale work on redirect.
// Optional: IF_PERF_CNT_EN adds saturating perf_fetched/perf_dropped/perf_starve.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   en                - fetch enable (gates new requests only)
//   pcsrc, pctarget   - redirect strobe and target
//   bus (master)      - imem request/response and decode output handshake
//   perf_* (optional) - performance counters
module if_prefetch_stage #(
  parameter int              XLEN            = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       pcsrc,
  input  logic [XLEN-1:0]            pctarget,
  if_prefetch_stage_if.master        bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_dropped,
  output logic [31:0]                perf_starve
`endif
);

  import riscv_pkg::*;

  localparam int DCW = $clog2(FIFO_DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int DW  = $bits(if_id_t);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [TCW-1:0]  drop_q, drop_d;
  logic            active_q;
  logic [TCW-1:0]  tag_count;
  logic [XLEN-1:0] tag_head;
  logic [DCW-1:0]  data_count;
  logic [DW-1:0]   data_head;
  if_id_t          push_entry;
  logic            credit_ok, req_fire, rsp_take, push_en, pop_en;

  // Tag-queue occupancy is the outstanding count; reserving queue space per
  // request means every response always has a slot.
  assign credit_ok = (int'(tag_count) < MAX_OUTSTANDING) &&
                     (int'(tag_count) + int'(data_count) < FIFO_DEPTH);

  // active_q keeps req_valid low while reset is asserted and for its release cycle.
  assign bus.imem_req_valid = active_q && en && !pcsrc && credit_ok;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Responses with nothing outstanding (stray after reset) are ignored.
  assign rsp_take = bus.imem_rsp_valid && (tag_count != '0);
  assign push_en  = rsp_take && (drop_q == '0) && !pcsrc;
  assign pop_en   = bus.out_valid && bus.out_ready;

  assign push_entry = '{pc: tag_head, pc_plus4: tag_head + XLEN'(4), instr: bus.imem_rsp_data};

  assign bus.out_valid = (data_count != '0);
  assign bus.out       = bus.out_valid ? if_id_t'(data_head) : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (pcsrc)         fetch_pc_d = {pctarget[XLEN-1:2], 2'b00};
    else if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);

    // On redirect everything still in flight after this cycle is stale; the
    // tag queue already counts older stale requests, so this also accumulates.
    drop_d = drop_q;
    if (pcsrc)                          drop_d = tag_count - TCW'(rsp_take);
    else if (rsp_take && drop_q != '0)  drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      active_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      active_q   <= 1'b1;
    end
  end

  // Tag queue is never flushed: stale responses still retire their tag.
  if_prefetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (1'b0),
    .push_i      (req_fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (rsp_take),
    .head_o      (tag_head),
    .count_o     (tag_count)
  );

  if_prefetch_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_data_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (pcsrc),
    .push_i      (push_en),
    .push_data_i (push_entry),
    .pop_i       (pop_en),
    .head_o      (data_head),
    .count_o     (data_count)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_dropped_q, perf_starve_q;
  logic [31:0] drop_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // Flush discards every queued entry; a pop in the redirect cycle does not happen.
  assign drop_inc = 32'(rsp_take && !push_en) + (pcsrc ? 32'(data_count) : 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      perf_fetched_q <= sat_add(perf_fetched_q, 32'(push_en));
      perf_dropped_q <= sat_add(perf_dropped_q, drop_inc);
      perf_starve_q  <= sat_add(perf_starve_q, 32'(bus.out_ready && !bus.out_valid));
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_starve  = perf_starve_q;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb/tb_if_prefetch_stage.sv - scoreboard bench for if_prefetch_stage
module tb_if_prefetch_stage;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        pcsrc = 1'b0;
  logic [31:0] pctarget = '0;

  if_prefetch_stage_if #(.XLEN(32)) bus();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped, perf_starve;
`endif

  if_prefetch_stage #(
    .XLEN(32), .RESET_PC(32'h100), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pcsrc    (pcsrc),
    .pctarget (pctarget),
    .bus      (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped),
    .perf_starve  (perf_starve)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  req_t        pipe[$];
  if_id_t      sb[$];
  logic [31:0] acc_addrs[$];
  int          acc_cycs[$];
  int          cycle = 0;
  int          epoch = 0;
  int          mem_lat = 1;
  bit          stray = 0;
  int          acc_count = 0;
  logic [31:0] last_acc_addr = '0;
  bit          got_acc = 0;
  logic [31:0] first_acc_addr = '0;
  int          out_count = 0;
  bit          got_out = 0;
  logic [31:0] first_out_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Instruction memory: in-order, fixed latency per request; responses to
  // requests issued before the latest redirect are expected to be dropped.
  initial begin : memory
    req_t r;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pipe.delete();
      end else begin
        if (bus.imem_rsp_valid && pipe.size() > 0) begin
          r = pipe.pop_front();
          if (r.epoch == epoch)
            sb.push_back('{pc: r.addr, pc_plus4: r.addr + 32'd4, instr: mem_word(r.addr)});
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          pipe.push_back('{addr: bus.imem_req_addr, epoch: epoch, due: cycle + mem_lat});
          acc_count++;
          acc_addrs.push_back(bus.imem_req_addr);
          acc_cycs.push_back(cycle);
          last_acc_addr = bus.imem_req_addr;
          if (!got_acc) begin
            got_acc = 1;
            first_acc_addr = bus.imem_req_addr;
          end
        end
      end
      @(posedge clk);
      #1;
      cycle++;
      if (stray) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_BAD0;
        stray = 0;
      end else if (rst_n && pipe.size() > 0 && pipe[0].due <= cycle) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pipe[0].addr);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
    end
  end

  initial begin : monitor
    if_id_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || pcsrc) begin
        sb.delete();
      end else if (bus.out_valid && bus.out_ready) begin
        out_count++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected actual pc=%h instr=%h expected=none", bus.out.pc, bus.out.instr);
        end else begin
          e = sb.pop_front();
          if (bus.out !== e) begin
            failures++;
            $display("FAIL out_entry actual pc=%h pc4=%h instr=%h expected pc=%h pc4=%h instr=%h",
                     bus.out.pc, bus.out.pc_plus4, bus.out.instr, e.pc, e.pc_plus4, e.instr);
          end
        end
        if (!got_out) begin
          got_out = 1;
          first_out_pc = bus.out.pc;
        end
      end
    end
  end

  task automatic wait_out(input string nm);
    for (int i = 0; i < 40 && !got_out; i++) begin
      @(posedge clk);
      #1;
    end
    chk(nm, 32'(got_out), 32'd1);
  endtask

  task automatic wait_pipe2(input string nm);
    for (int i = 0; i < 30 && pipe.size() != 2; i++) begin
      @(posedge clk);
      #1;
    end
    chk(nm, pipe.size(), 32'd2);
  endtask

  initial begin : stim
    int          o0, a0;
    logic [31:0] la;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out.pc, 32'd0);
    chk("rst_out_instr", bus.out.instr, 32'd0);

    // 1: sequential fetch from RESET_PC, single-cycle memory
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30 && acc_addrs.size() < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("t1_acc_cnt", 32'(acc_addrs.size() >= 4), 32'd1);
    if (acc_addrs.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("t1_addr%0d", i), acc_addrs[i], 32'h100 + 32'(4 * i));
      chk("t1_consec", 32'(acc_cycs[3] - acc_cycs[0]), 32'd3);
    end
    o0 = out_count;
    repeat (10) @(posedge clk);
    #1;
    chk("t1_throughput", 32'(out_count - o0), 32'd10);

    // 2: decode stall fills exactly FIFO_DEPTH entries
    bus.out_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    chk("t2_queued", sb.size(), 32'd4);
    chk("t2_inflight", pipe.size(), 32'd0);
    bus.out_ready = 1'b1;

    // 3: redirect with two 3-cycle requests in flight
    mem_lat = 3;
    wait_pipe2("t3_two_inflight");
    pcsrc = 1'b1; pctarget = 32'h203; epoch++; got_acc = 0; got_out = 0;
    @(posedge clk); #1;
    pcsrc = 1'b0;
    @(negedge clk);
    chk("t3_out_valid_n1", 32'(bus.out_valid), 32'd0);
    wait_out("t3_resume");
    chk("t3_first_addr", first_acc_addr, 32'h200);
    chk("t3_first_pc", first_out_pc, 32'h200);

    // 4: redirect coinciding with a response and a pop
    mem_lat = 1;
    repeat (8) @(posedge clk);
    #1;
    pcsrc = 1'b1; pctarget = 32'h300; epoch++; got_acc = 0; got_out = 0;
    @(negedge clk);
    chk("t4_rsp_in_cycle", 32'(bus.imem_rsp_valid), 32'd1);
    chk("t4_pop_in_cycle", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    pcsrc = 1'b0;
    @(negedge clk);
    chk("t4_empty_n1", 32'(bus.out_valid), 32'd0);
    wait_out("t4_resume");
    chk("t4_first_addr", first_acc_addr, 32'h300);
    chk("t4_first_pc", first_out_pc, 32'h300);

    // 5: en low with two requests in flight
    mem_lat = 3;
    repeat (4) @(posedge clk);
    #1;
    wait_pipe2("t5_two_inflight");
    en = 1'b0;
    a0 = acc_count;
    la = last_acc_addr;
    repeat (8) @(negedge clk);
    chk("t5_drained", 32'(bus.out_valid), 32'd0);
    chk("t5_req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    chk("t5_no_new_req", 32'(acc_count - a0), 32'd0);
    chk("t5_landed", pipe.size(), 32'd0);
    got_acc = 0;
    en = 1'b1;
    for (int i = 0; i < 10 && !got_acc; i++) begin
      @(posedge clk); #1;
    end
    chk("t5_resume_addr", first_acc_addr, la + 32'd4);

    // 6: mid-stream reset followed by a stray response
    mem_lat = 1;
    bus.out_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_out_pc", bus.out.pc, 32'd0);
    got_acc = 0; got_out = 0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    stray = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_out("t6_resume");
    chk("t6_first_addr", first_acc_addr, 32'h100);
    chk("t6_first_pc", first_out_pc, 32'h100);

    // Drain everything still expected
    en = 1'b0;
    for (int i = 0; i < 50 && (pipe.size() != 0 || sb.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_sb", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Parametrised instruction-fetch stage with a decoupled prefetch queue; successor to the single-register fetch stage.
- Issues in-order requests to instruction memory over a valid/ready interface with up to MAX_OUTSTANDING requests in flight.
- Buffers {pc, pc_plus4, instr} in a FIFO_DEPTH queue and presents it to decode through a valid/ready handshake.
- A redirect (pcsrc/pctarget) flushes the queue and discards stale in-flight responses.

Parameters:
- XLEN, 32: address/instruction width.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- FIFO_DEPTH, 4: prefetch queue entries; power of two, at least 2.
- MAX_OUTSTANDING, 2: maximum in-flight memory requests; 1 to FIFO_DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  fetch enable; 0 blocks new requests only, queue still drains.
- pcsrc  in  1  redirect strobe from execute.
- pctarget  in  XLEN  redirect target.
- imem_req_valid  out  1  memory request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  XLEN  instruction word.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out  out  if_id_t  head entry {pc, pc_plus4, instr}.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; drop count = 0.
  - imem_req_valid = 0, out_valid = 0, out = '0.
- Request rule: imem_req_valid = en && !pcsrc && (outstanding < MAX_OUTSTANDING) && (outstanding + occupancy < FIFO_DEPTH).
  - The credit check guarantees the queue never overflows.
- Request address: imem_req_addr = fetch_pc. On req_valid && req_ready, fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding increments.
- Response handling:
  - When drop count > 0, the response is discarded and drop count decrements.
  - Otherwise {pc, pc + 4, data} is pushed. The pc comes from an internal in-order PC tag queue of depth MAX_OUTSTANDING.
  - Every response decrements outstanding.
- Output: out_valid = !empty; out = head. The head pops on out_valid && out_ready.
  - Push and pop may occur in the same cycle, including when the queue is full or empty.
- Redirect (pcsrc = 1 in cycle N):
  - No request is issued in cycle N.
  - At edge N: queue flushed, fetch_pc = {pctarget[XLEN-1:2], 2'b00}.
  - Drop count = outstanding, counted after any acceptance or response in cycle N; a response arriving in cycle N is itself dropped.
  - Pop in cycle N: ignored for queue state (flush wins).
  - First new request: cycle N+1. out_valid = 0 in cycle N+1.
- Back-to-back redirects: each one reloads fetch_pc; drop count accumulates correctly.
- en = 0 mid-stream: outstanding responses still land and drain; no new requests.
- Response with outstanding = 0 (e.g. after mid-operation reset): ignored.
- Steady-state throughput: 1 instruction/cycle with single-cycle memory and MAX_OUTSTANDING ≥ 2.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_fetched (32 bits): responses pushed.
  - perf_dropped (32 bits): responses discarded plus entries flushed.
  - perf_starve (32 bits): cycles with out_ready && !out_valid.
  - All three are saturating, reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared riscv_pkg holds:
  - if_id_t {pc, pc_plus4, instr}, which already exists there.
  - NOP_INSTR (32'h0000_0013).
  - The XLEN default.
- One sub-module: if_prefetch_fifo, a parametrised synchronous FIFO with flush, simultaneous push/pop, and count output.
- The PC tag queue is a second instance of if_prefetch_fifo.

Test Plan:
1. Reset with RESET_PC = 0x100, en = 1, memory always ready with 1-cycle latency -> addresses 0x100, 0x104, 0x108… on consecutive cycles; out.pc/instr match in order; one output per cycle from cycle 3.
2. out_ready = 0 for 10 cycles, FIFO_DEPTH = 4 -> req_valid deasserts once outstanding + occupancy = 4; no entry lost or duplicated after out_ready returns to 1.
3. Two requests outstanding with 3-cycle latency, pcsrc = 1 with pctarget = 0x203 -> both late responses dropped; next request addr = 0x200; first out.pc = 0x200.
4. pcsrc asserted in the same cycle as a response and a pop -> the response is dropped, the queue is empty next cycle, fetch resumes at target.
5. en = 0 with 2 requests in flight -> both land in the queue; no further requests; resuming en continues at the next sequential PC.
6. rst_n pulsed low mid-stream, then a stray response -> outputs zero immediately; the stray response is ignored; fetch restarts at RESET_PC.
